// File: rtl/alu_exec_unit.sv
// Multi-cycle 8-bit execute unit feeding the ALU result latch; pulses grab once per completed op.
// Define ALU_DIV_EN to build the restoring divider for opcode 9; otherwise opcode 9 is illegal.
module alu_exec_unit #(
  parameter int MUL_ITERS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [7:0]  operand_a,
  input  logic [7:0]  operand_b,
  output logic        busy,
  output logic        grab,
  output logic [15:0] alu_result,
  output logic [2:0]  flags
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'd9;
`endif
  localparam logic [3:0] LAST_ITER = 4'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0]  src_reg;
  logic [7:0]  acc_hi;
  logic [7:0]  acc_lo;
  logic [3:0]  iter_cnt;
  logic        iter_last;
  logic        is_multi;

  logic [15:0] sc_result;
  logic        sc_carry;
  logic        sc_legal;
  logic        sc_wide;
  logic [2:0]  sc_flags;

  logic [8:0]  mul_sum;
  logic [7:0]  mul_hi;
  logic [7:0]  mul_lo;
  logic [7:0]  step_hi;
  logic [7:0]  step_lo;
  logic [15:0] step_result;

`ifdef ALU_DIV_EN
  logic        op_is_div;
  logic [8:0]  div_shift;
  logic        div_ok;
  logic [7:0]  div_hi;
  logic [7:0]  div_lo;
`endif

  // Single-cycle results are computed straight from the decode-stage inputs.
  always_comb begin
    sc_result = 16'h0000;
    sc_carry  = 1'b0;
    sc_legal  = 1'b1;
    sc_wide   = 1'b0;
    case (opcode)
      OP_ADD: {sc_carry, sc_result[7:0]} = {1'b0, operand_a} + {1'b0, operand_b};
      OP_SUB: begin
        sc_result[7:0] = operand_a - operand_b;
        sc_carry       = (operand_a < operand_b);
      end
      OP_AND: sc_result[7:0] = operand_a & operand_b;
      OP_OR:  sc_result[7:0] = operand_a | operand_b;
      OP_XOR: sc_result[7:0] = operand_a ^ operand_b;
      OP_NOT: sc_result[7:0] = ~operand_a;
      OP_SHL: begin
        sc_result[7:0] = {operand_a[6:0], 1'b0};
        sc_carry       = operand_a[7];
      end
      OP_SHR: begin
        sc_result[7:0] = {1'b0, operand_a[7:1]};
        sc_carry       = operand_a[0];
      end
      OP_MUL: sc_wide = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV: begin
        sc_result = 16'hFFFF;
        sc_carry  = 1'b1;
        sc_wide   = 1'b1;
      end
`endif
      default: sc_legal = 1'b0;
    endcase
  end

  assign sc_flags = sc_legal ? {sc_carry, (sc_result == 16'h0000),
                                (sc_wide ? sc_result[15] : sc_result[7])}
                             : 3'b100;

  // Divide by zero never enters ITER; it completes as a single-cycle error result.
  always_comb begin
    is_multi = (opcode == OP_MUL);
`ifdef ALU_DIV_EN
    if ((opcode == OP_DIV) && (operand_b != 8'd0)) begin
      is_multi = 1'b1;
    end
`endif
  end

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, src_reg} : 9'd0);
  assign mul_hi  = mul_sum[8:1];
  assign mul_lo  = {mul_sum[0], acc_lo[7:1]};

`ifdef ALU_DIV_EN
  // Restoring step: acc_hi holds the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi, acc_lo[7]};
  assign div_ok    = (div_shift >= {1'b0, src_reg});
  assign div_hi    = div_ok ? 8'(div_shift - {1'b0, src_reg}) : div_shift[7:0];
  assign div_lo    = {acc_lo[6:0], div_ok};
  assign step_hi   = op_is_div ? div_hi : mul_hi;
  assign step_lo   = op_is_div ? div_lo : mul_lo;
`else
  assign step_hi   = mul_hi;
  assign step_lo   = mul_lo;
`endif

  assign step_result = {step_hi, step_lo};
  assign iter_last   = (iter_cnt == LAST_ITER);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = is_multi ? ITER : DONE;
        end
      end
      ITER: begin
        if (iter_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign grab = (state == DONE);

  // Outputs only move on completion, so the latch sees stable values between grabs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      alu_result <= 16'h0000;
      flags      <= 3'b000;
      src_reg    <= 8'h00;
      acc_hi     <= 8'h00;
      acc_lo     <= 8'h00;
      iter_cnt   <= 4'd0;
`ifdef ALU_DIV_EN
      op_is_div  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            iter_cnt <= 4'd0;
            if (is_multi) begin
              acc_hi <= 8'h00;
              if (opcode == OP_MUL) begin
                src_reg <= operand_a;
                acc_lo  <= operand_b;
              end else begin
                src_reg <= operand_b;
                acc_lo  <= operand_a;
              end
`ifdef ALU_DIV_EN
              op_is_div <= (opcode == OP_DIV);
`endif
            end else begin
              alu_result <= sc_result;
              flags      <= sc_flags;
            end
          end
        end
        ITER: begin
          acc_hi   <= step_hi;
          acc_lo   <= step_lo;
          iter_cnt <= iter_cnt + 4'd1;
          if (iter_last) begin
            alu_result <= step_result;
            flags      <= {1'b0, (step_result == 16'h0000), step_result[15]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops against an arithmetic model.
`timescale 1ns/1ps
module tb_alu_exec_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  opcode;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic        busy;
  logic        grab;
  logic [15:0] alu_result;
  logic [2:0]  flags;

  int test_count = 0;
  int fail_count = 0;

  alu_exec_unit #(.MUL_ITERS(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .grab       (grab),
    .alu_result (alu_result),
    .flags      (flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Reference model: returns {flags, result} from plain integer arithmetic.
  function automatic logic [18:0] model(input int op, input int a, input int b);
    int  r;
    bit  c;
    bit  wide;
    bit  legal;
    r = 0; c = 0; wide = 0; legal = 1;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b) > 255; end
      1: begin r = (a - b + 256) % 256; c = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = (a * 2) % 256; c = a >= 128; end
      7: begin r = a / 2; c = (a % 2) == 1; end
      8: begin r = a * b; wide = 1; end
      9: begin
        if (!DIV_EN) legal = 0;
        else if (b == 0) begin r = 65535; c = 1; wide = 1; end
        else begin r = (a % b) * 256 + (a / b); wide = 1; end
      end
      default: legal = 0;
    endcase
    if (!legal) return {3'b100, 16'h0000};
    return {c, (r == 0), (wide ? (r >= 32768) : ((r % 256) >= 128)), 16'(r)};
  endfunction

  function automatic int model_latency(input int op, input int b);
    if (op == 8) return 9;
    if (op == 9 && DIV_EN && b != 0) return 9;
    return 1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issue one op, wait (bounded) for grab, and check latency, outputs and hold behaviour.
  task automatic apply_stimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [18:0] exp_val;
    int          lat;
    int          cycles;
    exp_val = model(int'(op), int'(a), int'(b));
    lat     = model_latency(int'(op), int'(b));
    @(negedge clock);
    start = 1'b1; opcode = op; operand_a = a; operand_b = b;
    @(negedge clock);
    start = 1'b0; opcode = 4'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
    cycles = 1;
    check_output({tag, "_busy"}, 32'(busy), 32'd1);
    while (!grab && cycles < 20) begin
      @(negedge clock);
      cycles++;
    end
    check_output({tag, "_grab"}, 32'(grab), 32'd1);
    check_output({tag, "_latency"}, 32'(cycles), 32'(lat));
    check_output({tag, "_result"}, 32'(alu_result), 32'(exp_val[15:0]));
    check_output({tag, "_flags"}, 32'(flags), 32'(exp_val[18:16]));
    @(negedge clock);
    check_output({tag, "_grab_off"}, 32'(grab), 32'd0);
    check_output({tag, "_idle"}, 32'(busy), 32'd0);
    check_output({tag, "_hold"}, 32'({flags, alu_result}), 32'(exp_val));
  endtask

  initial begin
    int grabs;
    logic [18:0] exp_val;
    reset = 1'b0; start = 1'b0; opcode = 4'd0; operand_a = 8'd0; operand_b = 8'd0;
    repeat (2) @(negedge clock);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_grab", 32'(grab), 32'd0);
    check_output("reset_result", 32'(alu_result), 32'd0);
    check_output("reset_flags", 32'(flags), 32'd0);
    reset = 1'b1;

    apply_stimulus(4'd0, 8'hF0, 8'h20, "add");
    check_output("add_plan", 32'({flags, alu_result}), {13'd0, 3'b100, 16'h0010});
    apply_stimulus(4'd1, 8'h05, 8'h05, "sub");
    check_output("sub_plan", 32'({flags, alu_result}), {13'd0, 3'b010, 16'h0000});
    apply_stimulus(4'd8, 8'hFF, 8'hFF, "mul");
    check_output("mul_plan", 32'({flags, alu_result}), {13'd0, 3'b001, 16'hFE01});
    apply_stimulus(4'd6, 8'h81, 8'h00, "shl");
    check_output("shl_plan", 32'({flags, alu_result}), {13'd0, 3'b100, 16'h0002});
    apply_stimulus(4'hF, 8'h12, 8'h34, "illegal");
    check_output("illegal_plan", 32'({flags, alu_result}), {13'd0, 3'b100, 16'h0000});
    apply_stimulus(4'd9, 8'd200, 8'd7, "div");
    apply_stimulus(4'd9, 8'd77, 8'd0, "div0");
`ifdef ALU_DIV_EN
    check_output("div0_plan", 32'({flags, alu_result}), {13'd0, 3'b101, 16'hFFFF});
`else
    check_output("div0_plan", 32'({flags, alu_result}), {13'd0, 3'b100, 16'h0000});
`endif

    // Reset held two cycles in the middle of a multiply must abort it without a grab.
    apply_stimulus(4'd0, 8'h11, 8'h22, "pre_reset");
    @(negedge clock);
    start = 1'b1; opcode = 4'd8; operand_a = 8'hFF; operand_b = 8'hFF;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    grabs = 0;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_result", 32'(alu_result), 32'd0);
    check_output("abort_flags", 32'(flags), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (grab) grabs++;
      @(negedge clock);
    end
    check_output("abort_no_grab", 32'(grabs), 32'd0);

    // start held high through a multiply: one grab, then the next start is taken from IDLE.
    @(negedge clock);
    start = 1'b1; opcode = 4'd8; operand_a = 8'hFF; operand_b = 8'hFF;
    @(negedge clock);
    opcode = 4'd0; operand_a = 8'h01; operand_b = 8'h02;
    grabs = 0;
    for (int i = 1; i <= 9; i++) begin
      if (grab) begin
        grabs++;
        check_output("stream_grab_cycle", 32'(i), 32'd9);
      end
      if (i < 9) @(negedge clock);
    end
    check_output("stream_one_grab", 32'(grabs), 32'd1);
    check_output("stream_mul_result", 32'(alu_result), 32'hFE01);
    @(negedge clock);
    check_output("stream_idle_busy", 32'(busy), 32'd0);
    check_output("stream_idle_grab", 32'(grab), 32'd0);
    @(negedge clock);
    start = 1'b0;
    check_output("stream_next_grab", 32'(grab), 32'd1);
    check_output("stream_next_result", 32'(alu_result), 32'h0003);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] rop;
      logic [7:0] ra;
      logic [7:0] rb;
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      apply_stimulus(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    exp_val = model(8, 8'h0F, 8'h11);
    apply_stimulus(4'd8, 8'h0F, 8'h11, "mul_small");
    check_output("mul_small_model", 32'(alu_result), 32'(exp_val[15:0]));

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
